// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the bit-serial subtractor: the FSM state
//   encoding and the default operand width.
package serial_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub.sv
// full_sub
//   One-bit full subtractor built from gate primitives.
//   Computes x - y - bin.
// Ports
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit, x ^ y ^ bin
//   bout : borrow out, (~x & y) | (~(x ^ y) & bin)
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic x_xor_y;
    logic x_xnor_y;
    logic x_n;
    logic term_xy;
    logic term_bin;

    xor g_xy   (x_xor_y, x, y);
    xor g_d    (d, x_xor_y, bin);
    not g_xn   (x_n, x);
    not g_xnor (x_xnor_y, x_xor_y);
    and g_t0   (term_xy, x_n, y);
    and g_t1   (term_bin, x_xnor_y, bin);
    or  g_bout (bout, term_xy, term_bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub
//   Bit-serial subtractor: computes a - b one bit per clock, LSB first,
//   through a single full_sub stage.
//   Timeline: the edge that accepts start loads the operands, W RUN cycles
//   each retire one bit, and the DONE cycle publishes the result, so done
//   rises W+1 cycles after the accepting edge. busy covers RUN and DONE.
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : begin a subtraction (accepted only when idle)
//   a, b   : operands, sampled only on the accepting edge
//   busy   : high while an operation is in progress
//   done   : one-cycle pulse when diff/borrow/ovf are updated
//   diff   : a - b mod 2^W, held until the next result
//   borrow : 1 when unsigned a < b
//   ovf    : two's-complement overflow of a - b
module serial_sub
    import serial_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         ovf
);

    // One extra bit so the counter can represent W without wrapping.
    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    state_t           state_reg;
    logic [W-1:0]     a_sh_reg;
    logic [W-1:0]     b_sh_reg;
    logic [W-1:0]     res_sh_reg;
    logic             bor_reg;
    logic [CNT_W-1:0] cnt_reg;
    // Operand sign bits are shifted out during RUN, so keep them for ovf.
    logic             a_msb_reg;
    logic             b_msb_reg;

    logic             busy_reg;
    logic             done_reg;
    logic [W-1:0]     diff_reg;
    logic             borrow_reg;
    logic             ovf_reg;

    logic             bit_d;
    logic             bit_bout;

    full_sub u_full_sub (
        .x    (a_sh_reg[0]),
        .y    (b_sh_reg[0]),
        .bin  (bor_reg),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            bor_reg    <= 1'b0;
            cnt_reg    <= '0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        a_msb_reg <= a[W-1];
                        b_msb_reg <= b[W-1];
                        bor_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // Consume the LSBs; the difference bit enters at the
                    // top so after W shifts the result is LSB-aligned.
                    a_sh_reg   <= {1'b0, a_sh_reg[W-1:1]};
                    b_sh_reg   <= {1'b0, b_sh_reg[W-1:1]};
                    res_sh_reg <= {bit_d, res_sh_reg[W-1:1]};
                    bor_reg    <= bit_bout;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg   <= 1'b1;
                    diff_reg   <= res_sh_reg;
                    borrow_reg <= bor_reg;
                    ovf_reg    <= (a_msb_reg != b_msb_reg) &&
                                  (res_sh_reg[W-1] != a_msb_reg);
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign diff   = diff_reg;
    assign borrow = borrow_reg;
    assign ovf    = ovf_reg;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub
//   Scoreboard bench for serial_sub (W = 8). Stimulus pushes the expected
//   result when an operation is issued; a monitor pops on every done pulse.
module tb_serial_sub;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_ops  = 0;

    serial_sub #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
        exp_t e;
        e.diff   = d;
        e.borrow = bo;
        e.ovf    = ov;
        return e;
    endfunction

    // Reference model for the random sweep.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.diff   = x - y;
        e.borrow = (x < y);
        e.ovf    = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (no op outstanding)");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_ops++;
                $display("op %0d: diff=%02h borrow=%0d ovf=%0d (exp %02h %0d %0d)",
                         n_ops, diff, borrow, ovf, e.diff, e.borrow, e.ovf);
                check("diff", int'(diff), int'(e.diff));
                check("borrow", int'(borrow), int'(e.borrow));
                check("ovf", int'(ovf), int'(e.ovf));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the accepting edge until done, and busy samples.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        if (busy) busy_cnt++;
        while (!done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        int lat;
        int bc;
        exp_q.push_back(e);
        start_op(x, y);
        wait_done(lat, bc);
        check("done_latency", lat, W + 1);
        check("busy_cycles", bc, W + 1);
    endtask

    initial begin
        int lat;
        int bc;
        int done_seen;
        logic [W-1:0] x;
        logic [W-1:0] y;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_borrow", int'(borrow), 0);
        check("rst_ovf", int'(ovf), 0);

        // Start on the first edge with reset released.
        rst_n = 1'b1;
        run_op(8'd100, 8'd37, mk(8'd63, 1'b0, 1'b0));
        run_op(8'd5,   8'd10, mk(8'hFB, 1'b1, 1'b0));
        run_op(8'h80,  8'h01, mk(8'h7F, 1'b0, 1'b1));
        run_op(8'h7F,  8'hFF, mk(8'h80, 1'b1, 1'b1));
        run_op(8'h5A,  8'h5A, mk(8'h00, 1'b0, 1'b0));
        run_op(8'h00,  8'hFF, mk(8'h01, 1'b1, 1'b0));

        // Start re-asserted during RUN and DONE is ignored.
        exp_q.push_back(mk(8'd30, 1'b0, 1'b0));
        start_op(8'd50, 8'd20);                 // after E0
        repeat (3) begin @(posedge clk); #1; end // after E3
        a = 8'd1; b = 8'd2; start = 1'b1;        // sampled at E4 (RUN)
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end // after E8: DONE cycle
        check("busy_in_done", int'(busy), 1);
        a = 8'd200; b = 8'd1; start = 1'b1;      // sampled at E9 (DONE)
        @(posedge clk); #1;                      // after E9
        check("done_after_ignore", int'(done), 1);
        // Held start in the following IDLE cycle is accepted.
        exp_q.push_back(mk(8'd5, 1'b0, 1'b0));
        a = 8'd9; b = 8'd4;
        @(posedge clk); #1;                      // accepted at E10
        start = 1'b0;
        wait_done(lat, bc);
        check("idle_start_latency", lat, W + 1);

        // Reset in the middle of RUN aborts the operation.
        start_op(8'd77, 8'd33);
        repeat (4) begin @(posedge clk); #1; end
        check("diff_held_while_busy", int'(diff), 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_diff", int'(diff), 0);
        check("midrst_borrow", int'(borrow), 0);
        check("midrst_ovf", int'(ovf), 0);
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("no_done_after_abort", done_seen, 0);
        run_op(8'h33, 8'h77, mk(8'hBC, 1'b1, 1'b0));

        // Random sweep against the reference model.
        for (int i = 0; i < 1000; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            run_op(x, y, model(x, y));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter W, default 8, giving the operand and result width in bits (W >= 2).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, a request to begin a subtraction A - B.
REQ-005 SHALL have port a, input, W bits, the unsigned/two's-complement minuend.
REQ-006 SHALL have port b, input, W bits, the subtrahend.
REQ-007 SHALL have port busy, output, 1 bit, high while a subtraction is in progress.
REQ-008 SHALL have port done, output, 1 bit, a one-cycle pulse when the result is valid.
REQ-009 SHALL have port diff, output, W bits, the result A - B mod 2^W.
REQ-010 SHALL have port borrow, output, 1 bit, the final borrow-out (1 iff unsigned A < B).
REQ-011 SHALL have port ovf, output, 1 bit, the two's-complement overflow of A - B.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE, latching a and b into two W-bit shift registers, clearing the borrow flop and bit counter, and moving to RUN.
REQ-014 SHALL, in each RUN cycle, process the LSB of each shift register through one full subtractor.
  - d = x^y^bin
  - bout = (~x&y) | (~(x^y)&bin)
REQ-015 SHALL, in each RUN cycle, shift d into the MSB of the result register, register bout, and increment the counter.
REQ-016 SHALL stay in RUN for exactly W cycles, then enter DONE.
REQ-017 SHALL, in DONE:
  - assert done for one cycle;
  - update diff, borrow and ovf from the result register;
  - return to IDLE.
REQ-018 SHALL compute ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the latched operand MSBs.
REQ-019 SHALL produce done exactly W+1 cycles after the edge that samples start; next start is accepted no earlier than the following IDLE cycle.
REQ-020 SHALL drive busy high in RUN and DONE and low in IDLE.
REQ-021 SHALL ignore start in RUN and DONE, with no effect on the operation in progress.
REQ-022 SHALL hold diff, borrow and ovf stable from the DONE cycle until the next DONE cycle.
REQ-023 SHALL not sample a and b outside the start-acceptance edge, so they may change freely while busy.
REQ-024 SHALL handle the boundary operands as follows:
  - a == b gives diff 0, borrow 0;
  - a = 0, b = 2^W-1 gives diff 1, borrow 1.

Reset
REQ-025 SHALL, when rst_n = 0 at a clock edge, force the following, overriding any operation in progress including mid-RUN:
  - FSM to IDLE;
  - busy, done, diff, borrow and ovf to 0;
  - shift registers, borrow flop and counter to 0.
REQ-026 SHALL give start priority below reset, and SHALL accept start on the first edge with rst_n = 1.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width constant in shared package serial_pkg.
REQ-028 SHALL instantiate one combinational sub-module full_sub (inputs x, y, bin; outputs d, bout), gate-level, for the per-bit step.
REQ-029 SHALL size the counter at $clog2(W)+1 bits to avoid wrap at count W.

Verification
REQ-030 SHALL cover: W=8, a=100, b=37, start one cycle -> done 9 cycles later; diff=63, borrow=0, ovf=0; busy high for 9 cycles.
REQ-031 SHALL cover: a=5, b=10 -> diff=251 (8'hFB), borrow=1, ovf=0.
REQ-032 SHALL cover: a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, ovf=1; also a=8'h7F, b=8'hFF -> diff=8'h80, borrow=1, ovf=1.
REQ-033 SHALL cover: start re-asserted with new a/b during RUN and DONE -> ignored, first result unchanged; start in next IDLE cycle accepted.
REQ-034 SHALL cover: rst_n low for one cycle at RUN cycle 4 -> all outputs 0, IDLE next cycle, no done pulse; a fresh start then completes correctly.
REQ-035 SHALL cover: exhaustive or random a, b over 1000 operations vs reference model (a-b) -> diff, borrow and ovf match on every done pulse.
